// File: rtl/inv_mix_columns_seq_if.sv
// inv_mix_columns_seq_if: valid/ready bus for the InvMixColumns unit (enc_mode present with MIXCOL_DUAL_MODE_EN)
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIXCOL_DUAL_MODE_EN
  logic         enc_mode;
  modport master (output in_valid, in_data, out_ready, enc_mode, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, enc_mode, output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns, one column per clock; MIXCOL_DUAL_MODE_EN adds forward mode via enc_mode
module inv_mix_columns_seq (
  input  logic                   clk,
  input  logic                   rst_n,
  inv_mix_columns_seq_if.slave   bus,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t       state;
  logic [1:0]   col_cnt;
  logic [127:0] work;
  logic [31:0]  col;
  logic [31:0]  col_f;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[24-8*i +: 8];
      m9[i] = xt(xt(xt(a[i]))) ^ a[i];
      mb[i] = m9[i] ^ xt(a[i]);
      md[i] = m9[i] ^ xt(xt(a[i]));
      me[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef MIXCOL_DUAL_MODE_EN
  logic enc;

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[24-8*i +: 8];
      m2[i] = xt(a[i]);
    end
    return {m2[0] ^ m2[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ m2[1] ^ m2[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ m2[2] ^ m2[3] ^ a[3],
            m2[0] ^ a[0] ^ a[1] ^ a[2] ^ m2[3]};
  endfunction

  assign col_f = enc ? fwd_col(col) : inv_col(col);
`else
  assign col_f = inv_col(col);
`endif

  assign col          = work[{col_cnt, 5'b0} +: 32];
  assign bus.out_data = work;

  // Handshake FSM: accept a state, transform one column per cycle, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      col_cnt       <= 2'd0;
      work          <= 128'h0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef MIXCOL_DUAL_MODE_EN
      enc           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state        <= COMPUTE;
          work         <= bus.in_data;
          col_cnt      <= 2'd0;
          bus.in_ready <= 1'b0;
          busy         <= 1'b1;
`ifdef MIXCOL_DUAL_MODE_EN
          enc          <= bus.enc_mode;
`endif
        end
        COMPUTE: begin
          work[{col_cnt, 5'b0} +: 32] <= col_f;
          col_cnt                     <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state         <= DONE;
            busy          <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: randomized and directed checks of inv_mix_columns_seq against a GF(2^8) matrix model
module tb_inv_mix_columns_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_bp = 1'b0;
  logic [127:0] exp_q [$];
  int   acc_q [$];

  inv_mix_columns_seq_if bus ();
  inv_mix_columns_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x = {1'b0, a};
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x[7:0];
      x = {x[7:0], 1'b0};
      if (x[8]) x ^= 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit enc);
    logic [7:0] inv_k [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] fwd_k [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [127:0] r = '0;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(enc ? fwd_k[(k - row + 4) % 4] : inv_k[(k - row + 4) % 4], s[c*32 + 24 - 8*k +: 8]);
        r[c*32 + 24 - 8*row +: 8] = acc;
      end
    return r;
  endfunction

  // Scoreboard: predict on accept, compare on output handshake, forget everything on reset
  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc);
`ifdef MIXCOL_DUAL_MODE_EN
        exp_q.push_back(model(bus.in_data, bus.enc_mode));
`else
        exp_q.push_back(model(bus.in_data, 1'b0));
`endif
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("sb_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [127:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic await_valid(input bit chk_lat);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("valid_timeout", 0, 1);
    else if (chk_lat) check("latency", n, 4);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_drain", bus.in_ready, 1);
    check("out_valid_after_drain", bus.out_valid, 0);
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (n >= bound) check("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] a, b;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef MIXCOL_DUAL_MODE_EN
    bus.enc_mode  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    send({32'h01010101, 32'h01010101, 32'h01010101, 32'h8e4da1bc});
    bus.in_valid = 1'b0;
    check("busy_compute", busy, 1);
    check("in_ready_compute", bus.in_ready, 0);
    await_valid(1'b1);
    check("vec1", bus.out_data, {32'h01010101, 32'h01010101, 32'h01010101, 32'hdb135345});
    check("busy_done", busy, 0);
    drain();

    send({32'hc6c6c6c6, 32'h4d7ebdf8, 32'hd5d5d7d6, 32'h9fdc589d});
    bus.in_valid = 1'b0;
    await_valid(1'b1);
    check("fips", bus.out_data, {32'hc6c6c6c6, 32'h2d26314c, 32'hd4d4d4d5, 32'hf20a225c});
    drain();

    send({$urandom(), $urandom(), $urandom(), $urandom()});
    await_valid(1'b1);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stable", bus.out_data, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    drain();
    send(bus.in_data);
    bus.in_valid = 1'b0;
    await_valid(1'b1);
    drain();

    acc_q.delete();
    bus.out_ready = 1'b1;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(a);
    send(b);
    bus.in_valid = 1'b0;
    wait_empty(40);
    bus.out_ready = 1'b0;
    if (acc_q.size() == 2) check("b2b_spacing", acc_q[1] - acc_q[0], 6);
    else check("b2b_accepts", acc_q.size(), 2);

    send({$urandom(), $urandom(), $urandom(), $urandom()});
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    send({$urandom(), $urandom(), $urandom(), $urandom()});
    bus.in_valid = 1'b0;
    await_valid(1'b1);
    drain();

`ifdef MIXCOL_DUAL_MODE_EN
    bus.enc_mode = 1'b1;
    send({32'h01010101, 32'h01010101, 32'h01010101, 32'hdb135345});
    bus.in_valid = 1'b0;
    bus.enc_mode = 1'b0;
    await_valid(1'b1);
    check("enc_fwd", bus.out_data[31:0], 32'h8e4da1bc);
    held = bus.out_data;
    drain();
    send(held);
    bus.in_valid = 1'b0;
    await_valid(1'b1);
    check("enc_roundtrip", bus.out_data[31:0], 32'hdb135345);
    drain();
`endif

    rnd_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
`ifdef MIXCOL_DUAL_MODE_EN
      bus.enc_mode = 1'($urandom_range(0, 1));
`endif
      send({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.in_valid = 1'b0;
    end
    wait_empty(500);
    rnd_bp = 1'b0;
    @(posedge clk); #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
